// File: rtl/exec_pkg.sv
// Shared RV32I issue/ALU definitions: opcodes, ALU control codes, issue packet.
package exec_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [7:0] ALU_NONE = 8'h00;
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_SUB  = 8'h02;
  localparam logic [7:0] ALU_XOR  = 8'h03;
  localparam logic [7:0] ALU_OR   = 8'h04;
  localparam logic [7:0] ALU_AND  = 8'h05;
  localparam logic [7:0] ALU_EQ   = 8'h06;
  localparam logic [7:0] ALU_NE   = 8'h07;
  localparam logic [7:0] ALU_LT   = 8'h08;
  localparam logic [7:0] ALU_GE   = 8'h09;
  localparam logic [7:0] ALU_LTU  = 8'h0a;
  localparam logic [7:0] ALU_GEU  = 8'h0b;
  localparam logic [7:0] ALU_SLL  = 8'h0c;
  localparam logic [7:0] ALU_SRL  = 8'h0d;
  localparam logic [7:0] ALU_SRA  = 8'h0e;

  typedef struct packed {
    logic [31:0] din1;
    logic [31:0] din2;
    logic [7:0]  control;
    logic [4:0]  rd;
    logic        we;
    logic        branch;
    logic        illegal;
  } issue_pkt_t;

  typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_FULL} buf_state_e;

endpackage

// File: rtl/exec_issue_if.sv
// Fetch-side and execute-side handshake bundle of exec_issue.
interface exec_issue_if #(parameter int unsigned XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [31:0]     in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_din1;
  logic [XLEN-1:0] alu_din2;
  logic [7:0]      alu_control;
  logic [4:0]      out_rd;
  logic            out_we;
  logic            out_branch;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, alu_din1, alu_din2, alu_control,
           out_rd, out_we, out_branch, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, alu_din1, alu_din2, alu_control,
           out_rd, out_we, out_branch, out_illegal
  );
endinterface

// File: rtl/exec_decode.sv
// Combinational RV32I decoder for the ALU-class subset; unknown encodings issue as illegal.
module exec_decode
  import exec_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output issue_pkt_t  pkt
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        bad;
  logic        wr;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign rd    = instr[11:7];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'b0};
  assign shamt = {27'b0, instr[24:20]};

  always_comb begin
    pkt = '0;
    bad = 1'b0;
    wr  = 1'b0;
    case (opc)
      OPC_OP: begin
        pkt.din1 = rs1_val;
        pkt.din2 = rs2_val;
        wr       = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  pkt.control = ALU_ADD;
            3'b001:  pkt.control = ALU_SLL;
            3'b010:  pkt.control = ALU_LT;
            3'b011:  pkt.control = ALU_LTU;
            3'b100:  pkt.control = ALU_XOR;
            3'b101:  pkt.control = ALU_SRL;
            3'b110:  pkt.control = ALU_OR;
            default: pkt.control = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          pkt.control = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          pkt.control = ALU_SRA;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        pkt.din1 = rs1_val;
        pkt.din2 = imm_i;
        wr       = 1'b1;
        case (f3)
          3'b000: pkt.control = ALU_ADD;
          3'b010: pkt.control = ALU_LT;
          3'b011: pkt.control = ALU_LTU;
          3'b100: pkt.control = ALU_XOR;
          3'b110: pkt.control = ALU_OR;
          3'b111: pkt.control = ALU_AND;
          3'b001: begin
            pkt.din2 = shamt;
            if (f7 == 7'b0000000) pkt.control = ALU_SLL;
            else                  bad = 1'b1;
          end
          default: begin
            pkt.din2 = shamt;
            if (f7 == 7'b0000000)      pkt.control = ALU_SRL;
            else if (f7 == 7'b0100000) pkt.control = ALU_SRA;
            else                       bad = 1'b1;
          end
        endcase
      end
      OPC_BRANCH: begin
        pkt.din1   = rs1_val;
        pkt.din2   = rs2_val;
        pkt.branch = 1'b1;
        case (f3)
          3'b000:  pkt.control = ALU_EQ;
          3'b001:  pkt.control = ALU_NE;
          3'b100:  pkt.control = ALU_LT;
          3'b101:  pkt.control = ALU_GE;
          3'b110:  pkt.control = ALU_LTU;
          3'b111:  pkt.control = ALU_GEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LUI: begin
        pkt.din2    = imm_u;
        pkt.control = ALU_ADD;
        wr          = 1'b1;
      end
      OPC_AUIPC: begin
        pkt.din1    = pc;
        pkt.din2    = imm_u;
        pkt.control = ALU_ADD;
        wr          = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      pkt         = '0;
      pkt.illegal = 1'b1;
    end else if (wr) begin
      pkt.rd = rd;
      pkt.we = (rd != 5'd0);
    end
  end

endmodule

// File: rtl/exec_issue.sv
// Issue stage: decode, optional writeback bypass (EXEC_ISSUE_FWD_EN), 2-entry output/skid buffer.
module exec_issue
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pause,
  exec_issue_if.slave     bus,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            fwd_we,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data
);

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  issue_pkt_t  dec_pkt;
  issue_pkt_t  out_q;
  issue_pkt_t  skid_q;
  buf_state_e  state;
  logic        in_ready;
  logic        accept;
  logic        drain;

  assign rs1_addr = bus.in_instr[19:15];
  assign rs2_addr = bus.in_instr[24:20];

`ifdef EXEC_ISSUE_FWD_EN
  assign rs1_val = (fwd_we && fwd_rd != 5'd0 && fwd_rd == rs1_addr) ? fwd_data : rs1_data;
  assign rs2_val = (fwd_we && fwd_rd != 5'd0 && fwd_rd == rs2_addr) ? fwd_data : rs2_data;
`else
  logic fwd_unused;
  assign fwd_unused = ^{fwd_we, fwd_rd, fwd_data};
  assign rs1_val    = rs1_data;
  assign rs2_val    = rs2_data;
`endif

  exec_decode u_decode (
    .instr   (bus.in_instr),
    .pc      (bus.in_pc),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .pkt     (dec_pkt)
  );

  assign in_ready = !pause && (state != BUF_FULL);
  assign accept   = bus.in_valid && in_ready;
  assign drain    = !pause && (state != BUF_EMPTY) && bus.out_ready;

  // out_q always holds the oldest packet; skid_q is only occupied in BUF_FULL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= BUF_EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else if (!pause) begin
      case (state)
        BUF_EMPTY: begin
          if (accept) begin
            out_q <= dec_pkt;
            state <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && drain) begin
            out_q <= dec_pkt;
          end else if (accept) begin
            skid_q <= dec_pkt;
            state  <= BUF_FULL;
          end else if (drain) begin
            state <= BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (drain) begin
            out_q <= skid_q;
            state <= BUF_ONE;
          end
        end
        default: state <= BUF_EMPTY;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state != BUF_EMPTY);
  assign bus.alu_din1    = out_q.din1;
  assign bus.alu_din2    = out_q.din2;
  assign bus.alu_control = out_q.control;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_we      = out_q.we;
  assign bus.out_branch  = out_q.branch;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_exec_issue.sv
// Scoreboard bench for exec_issue: directed vectors, expected packets queued at acceptance.
module tb_exec_issue;
  import exec_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        pause;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        fwd_we;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int total;
  int bad;
  issue_pkt_t sb[$];

  exec_issue_if #(.XLEN(32)) bus ();

  exec_issue #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .pause    (pause),
    .bus      (bus),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .fwd_we   (fwd_we),
    .fwd_rd   (fwd_rd),
    .fwd_data (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic issue_pkt_t mk(input logic [31:0] d1, input logic [31:0] d2,
                                    input logic [7:0] ctl, input logic [4:0] rd,
                                    input logic we, input logic br, input logic ill);
    issue_pkt_t p;
    p.din1 = d1; p.din2 = d2; p.control = ctl; p.rd = rd;
    p.we = we; p.branch = br; p.illegal = ill;
    return p;
  endfunction

  function automatic issue_pkt_t cur();
    return mk(bus.alu_din1, bus.alu_din2, bus.alu_control, bus.out_rd,
              bus.out_we, bus.out_branch, bus.out_illegal);
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Scoreboard monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && !pause && bus.out_valid && bus.out_ready) begin
      issue_pkt_t g;
      issue_pkt_t e;
      g = cur();
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pkt got=%h", g);
      end else begin
        e = sb.pop_front();
        if (g !== e) begin
          bad++;
          $display("FAIL pkt got=%h exp=%h", g, e);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    bus.in_instr = instr;
    bus.in_pc    = pc;
    rs1_data     = r1;
    rs2_data     = r2;
    bus.in_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2, input issue_pkt_t exp);
    drive(instr, pc, r1, r2);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(exp);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    total++;
    bad++;
    $display("FAIL send_timeout instr=%h in_ready=%b exp_ready=1", instr, bus.in_ready);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog sim_time=%0t limit=100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    issue_pkt_t pa, pb, pc_, pp, pq, psub;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    pause = 1'b0;
    fwd_we = 1'b0; fwd_rd = '0; fwd_data = '0;
    bus.out_ready = 1'b1;
    drive(32'hFFD08293, 32'h0, 32'd10, 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_outputs", cur(), '0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // ADDI x5,x1,-3 with one-cycle latency
    send(32'hFFD08293, 32'h0, 32'd10, 32'd0, mk(32'd10, 32'hFFFFFFFD, 8'h01, 5'd5, 1, 0, 0));
    @(negedge clk);
    chk("latency_valid", bus.out_valid, 1'b1);
    @(posedge clk); #1;

    send(32'h0020E063, 32'h0, 32'd1, 32'hFFFFFFFF, mk(32'd1, 32'hFFFFFFFF, 8'h0a, 5'd0, 0, 1, 0));
    send(32'h123453B7, 32'h0, 32'd99, 32'd0, mk(32'h0, 32'h12345000, 8'h01, 5'd7, 1, 0, 0));
    send(32'hABCDE417, 32'h1000, 32'd0, 32'd0, mk(32'h1000, 32'hABCDE000, 8'h01, 5'd8, 1, 0, 0));
    send(32'h40515493, 32'h0, 32'h80000000, 32'd0, mk(32'h80000000, 32'd5, 8'h0e, 5'd9, 1, 0, 0));
    send(32'hFFF0B213, 32'h0, 32'd3, 32'd0, mk(32'd3, 32'hFFFFFFFF, 8'h0a, 5'd4, 1, 0, 0));
    send(32'h00208033, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, 8'h01, 5'd0, 0, 0, 0));
    send(32'h0000A283, 32'h0, 32'd1, 32'd2, mk(32'h0, 32'h0, 8'h00, 5'd0, 0, 0, 1));
    send(32'h4020C1B3, 32'h0, 32'd1, 32'd2, mk(32'h0, 32'h0, 8'h00, 5'd0, 0, 0, 1));

    // SUB x3,x1,x1 with bypass active, then with fwd_rd=0
    fwd_we = 1'b1; fwd_rd = 5'd1; fwd_data = 32'd42;
`ifdef EXEC_ISSUE_FWD_EN
    psub = mk(32'd42, 32'd42, 8'h02, 5'd3, 1, 0, 0);
`else
    psub = mk(32'd7, 32'd5, 8'h02, 5'd3, 1, 0, 0);
`endif
    send(32'h401081B3, 32'h0, 32'd7, 32'd5, psub);
    fwd_rd = 5'd0;
    send(32'h401081B3, 32'h0, 32'd7, 32'd5, mk(32'd7, 32'd5, 8'h02, 5'd3, 1, 0, 0));
    fwd_we = 1'b0;
    wait_drain();

    // Back-pressure: three cycles of out_ready=0 with in_valid held
    pa  = mk(32'hF0, 32'h0F, 8'h04, 5'd10, 1, 0, 0);
    pb  = mk(32'hFF, 32'h3C, 8'h05, 5'd11, 1, 0, 0);
    pc_ = mk(32'd1, 32'd4, 8'h0c, 5'd12, 1, 0, 0);
    bus.out_ready = 1'b0;
    drive(32'h0020E533, 32'h0, 32'hF0, 32'h0F);
    @(negedge clk);
    chk("stall_ready_c1", bus.in_ready, 1'b1);
    sb.push_back(pa);
    @(posedge clk); #1;
    drive(32'h0020F5B3, 32'h0, 32'hFF, 32'h3C);
    @(negedge clk);
    chk("stall_ready_c2", bus.in_ready, 1'b1);
    sb.push_back(pb);
    @(posedge clk); #1;
    drive(32'h00209633, 32'h0, 32'd1, 32'd4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_ready_full", bus.in_ready, 1'b0);
      chk("stall_valid", bus.out_valid, 1'b1);
      chk("stall_hold_a", cur(), pa);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(32'h00209633, 32'h0, 32'd1, 32'd4, pc_);
    wait_drain();

    // Pause mid-stream freezes the buffer and blocks input
    pp = mk(32'd5, 32'd6, 8'h07, 5'd0, 0, 1, 0);
    pq = mk(32'h80000000, 32'd4, 8'h0d, 5'd13, 1, 0, 0);
    send(32'h00209063, 32'h0, 32'd5, 32'd6, pp);
    pause = 1'b1;
    drive(32'h0020D6B3, 32'h0, 32'h80000000, 32'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("pause_ready", bus.in_ready, 1'b0);
      chk("pause_valid", bus.out_valid, 1'b1);
      chk("pause_hold", cur(), pp);
      @(posedge clk); #1;
    end
    pause = 1'b0;
    send(32'h0020D6B3, 32'h0, 32'h80000000, 32'd4, pq);
    wait_drain();

    // Reset while both entries are occupied discards them
    bus.out_ready = 1'b0;
    send(32'h0020E533, 32'h0, 32'hF0, 32'h0F, pa);
    send(32'h0020F5B3, 32'h0, 32'hFF, 32'h3C, pb);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", bus.out_valid, 1'b0);
    chk("rstmid_outputs", cur(), '0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", bus.in_ready, 1'b1);
    chk("rstmid_empty", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    send(32'h0020D063, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, 8'h09, 5'd0, 0, 1, 0));
    wait_drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
